dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: byte-address width; memory holds 2**ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 0: wait states inserted between request accept and response, range 0..15.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  size/sign code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was illegal; no memory side effect.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; all req_* fields SHALL be captured at accept and later changes ignored.
REQ-017 IDLE->WAIT on accept when WAIT_CYCLES>0; IDLE->RESP on accept when WAIT_CYCLES=0.
REQ-018 WAIT SHALL load a counter with WAIT_CYCLES-1 on entry, decrement each cycle, and move to RESP on the cycle the counter is 0.
REQ-019 The memory read or write (commit) SHALL occur on the clock edge entering RESP; rsp_valid rises in the same cycle, giving a load latency of WAIT_CYCLES+1 cycles after accept.
REQ-020 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE on that edge; a new request can be accepted no earlier than the following cycle (no pipelining).
REQ-021 Memory is little-endian: a store writes bytes addr..addr+size-1 from req_wdata LSB first; a load reads them into rsp_rdata LSB first.
REQ-022 Load extension: 000/001 sign-extend, 100/101 zero-extend, 010 full word.
REQ-023 Illegal funct3 (011, 110, 111, or 100/101 with req_we=1) SHALL give rsp_err=1, rsp_rdata=0, and no write.
REQ-024 Byte addresses are computed modulo 2**ADDR_W.
REQ-025 Memory contents SHALL be retained across reset and are uninitialised at power-up.

Reset
REQ-026 On rst_n=0 the FSM SHALL go to IDLE, clear the counter, and drive req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 Reset in WAIT SHALL abort the transaction with no write; reset in RESP SHALL drop the response, while the write already committed stays.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN selects misaligned-access handling.
REQ-029 Misaligned means a half access with addr[0]=1 or a word access with addr[1:0]!=00.
REQ-030 With DMEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL give rsp_err=1, rsp_rdata=0, no write, and normal handshake timing.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, a misaligned access SHALL clear the offending low address bits, execute normally, and give rsp_err=0.

Verification
REQ-032 WAIT_CYCLES=0: SW addr 0x0010 data 0xDEADBEEF, then LW 0x0010 -> rsp_rdata 0xDEADBEEF, rsp_valid one cycle after accept.
REQ-033 After REQ-032: LB 0x0013 -> 0xFFFFFFDE; LBU 0x0013 -> 0x000000DE; LH 0x0010 -> 0xFFFFBEEF; LHU 0x0012 -> 0x0000DEAD.
REQ-034 SB 0x0011 data 0x000000AA over 0xDEADBEEF, then LW 0x0010 -> 0xDEADAAEF; funct3=011 store -> rsp_err=1 and the word is unchanged.
REQ-035 WAIT_CYCLES=3, rsp_ready held low for 2 cycles after rsp_valid rises: rsp_valid rises 4 cycles after accept, req_ready stays 0 throughout, data stays stable, and IDLE follows the rsp_ready edge.
REQ-036 LW 0x0012 -> with macro: rsp_err=1, rdata 0; without macro: rdata equals word at 0x0010, rsp_err=0.
REQ-037 WAIT_CYCLES=3: SW 0x0020 data 0x12345678, rst_n pulsed low in WAIT -> outputs at reset values, and a later LW 0x0020 returns the prior contents.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Byte-addressed data-memory controller: one request at a time, response WAIT_CYCLES+1 cycles after accept,
// response held until rsp_ready. Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rdata_q;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  logic              accept;
  logic              commit;
  logic              c_we;
  logic [2:0]        c_f3;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic              is_byte, is_half, is_word;
  logic              illegal, misal, err;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       load_val;

  assign accept = req_valid & req_ready_q;
  assign commit = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));

  // With zero wait states the commit edge is the accept edge, so operands come straight from the port.
  assign c_we    = (state_q == IDLE) ? req_we     : we_q;
  assign c_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign c_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

  always_comb begin
    is_byte = (c_f3[1:0] == 2'b00);
    is_half = (c_f3[1:0] == 2'b01);
    is_word = (c_f3[1:0] == 2'b10);
    illegal = (c_f3[1:0] == 2'b11) || (c_f3 == 3'b110) || (c_f3[2] && c_we);
    misal   = (is_half && c_addr[0]) || (is_word && (c_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    err = illegal || misal;
    a0  = c_addr;
`else
    err = illegal;
    a0  = c_addr;
    if (is_half) a0[0] = 1'b0;
    if (is_word) a0[1:0] = 2'b00;
`endif
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    load_val = 32'd0;
    if (!err && !c_we) begin
      case (c_f3)
        3'b000:  load_val = {{24{b0[7]}}, b0};
        3'b100:  load_val = {24'd0, b0};
        3'b001:  load_val = {{16{b1[7]}}, b1, b0};
        3'b101:  load_val = {16'd0, b1, b0};
        3'b010:  load_val = {b3, b2, b1, b0};
        default: load_val = 32'd0;
      endcase
    end
  end

  // No reset: contents survive rst_n; an aborted WAIT never reaches commit because state_q is forced to IDLE.
  always_ff @(posedge clk) begin
    if (commit && c_we && !err) begin
      mem[a0] <= c_wdata[7:0];
      if (!is_byte) mem[a1] <= c_wdata[15:8];
      if (is_word) begin
        mem[a2] <= c_wdata[23:16];
        mem[a3] <= c_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            f3_q        <= req_funct3;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err;
              rdata_q     <= load_val;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rdata_q     <= load_val;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench: instance 0 has no wait states, instance 1 has three; drivers push expected responses,
// per-instance monitors pop and compare on each response, also checking latency, stability and handshake.
module tb_dmem_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [15:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  logic [31:0] cyc;
  int          n_chk;
  int          n_fail;
  int          stall [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  dmem_ctrl #(.ADDR_W(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_ctrl #(.ADDR_W(16), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err[d]}, 32'd0);
  endtask

  task automatic issue(input int d, input logic we, input logic [2:0] f3, input logic [15:0] addr,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int st, input logic ab);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: dut %0d req_ready stayed 0, required 1", d);
      return;
    end
    e.rdata = er;
    e.err   = ee;
    e.acc   = cyc;
    if (!ab) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    stall[d]      = st;
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    @(negedge clk);
    req_valid[d]  = 1'b0;
    req_we[d]     = ~we;
    req_funct3[d] = 3'b111;
    req_addr[d]   = ~addr;
    req_wdata[d]  = ~wd;
    if (ab) begin
      rst_n[d] = 1'b0;
      #1;
      chk_reset(d);
      @(negedge clk);
      rst_n[d] = 1'b1;
    end else if (d == 1) begin
      for (int i = 0; i < 3; i++) begin
        chk("wait_req_ready", {31'd0, req_ready[d]}, 32'd0);
        chk("wait_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
        if (i < 2) @(negedge clk);
      end
    end
  endtask

  task automatic monitor(input int d);
    exp_t        e;
    logic        first;
    logic        exp_idle;
    logic        have;
    logic [31:0] sv_d;
    logic        sv_e;
    logic [31:0] lat_exp;
    first    = 1'b1;
    exp_idle = 1'b0;
    have     = 1'b0;
    sv_d     = 32'd0;
    sv_e     = 1'b0;
    lat_exp  = (d == 0) ? 32'd1 : 32'd4;
    forever begin
      @(negedge clk);
      if (!rst_n[d]) begin
        first        = 1'b1;
        exp_idle     = 1'b0;
        rsp_ready[d] = 1'b1;
        continue;
      end
      if (exp_idle) begin
        chk("idle_req_ready", {31'd0, req_ready[d]}, 32'd1);
        chk("idle_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
        exp_idle = 1'b0;
      end
      if (rsp_valid[d]) begin
        if (first) begin
          have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: dut %0d rdata 0x%08h with no pending request", d, rsp_rdata[d]);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("latency", cyc - e.acc, lat_exp);
            chk("rdata", rsp_rdata[d], e.rdata);
            chk("err", {31'd0, rsp_err[d]}, {31'd0, e.err});
          end
          sv_d  = rsp_rdata[d];
          sv_e  = rsp_err[d];
          first = 1'b0;
        end else begin
          chk("stable_rdata", rsp_rdata[d], sv_d);
          chk("stable_err", {31'd0, rsp_err[d]}, {31'd0, sv_e});
        end
        chk("busy_req_ready", {31'd0, req_ready[d]}, 32'd0);
        if (stall[d] > 0) begin
          rsp_ready[d] = 1'b0;
          stall[d]--;
        end else begin
          rsp_ready[d] = 1'b1;
        end
        if (rsp_ready[d]) begin
          first    = 1'b1;
          exp_idle = 1'b1;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    int n;
    n_chk  = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d]      = 1'b0;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = 3'd0;
      req_addr[d]   = 16'd0;
      req_wdata[d]  = 32'd0;
      rsp_ready[d]  = 1'b1;
      stall[d]      = 0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Zero-wait instance: store/load sizes, extension, illegal codes, wrap-around byte.
    issue(0, 1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b010, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b000, 16'h0013, 32'h0,        32'hFFFFFFDE, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b100, 16'h0013, 32'h0,        32'h000000DE, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b001, 16'h0010, 32'h0,        32'hFFFFBEEF, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b101, 16'h0012, 32'h0,        32'h0000DEAD, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 3'b000, 16'h0011, 32'h000000AA, 32'h00000000, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b010, 16'h0010, 32'h0,        32'hDEADAAEF, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 3'b011, 16'h0010, 32'h11111111, 32'h00000000, 1'b1, 0, 1'b0);
    issue(0, 1'b0, 3'b010, 16'h0010, 32'h0,        32'hDEADAAEF, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 3'b001, 16'h0012, 32'h00001234, 32'h00000000, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b010, 16'h0010, 32'h0,        32'h1234AAEF, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b001, 16'h0012, 32'h0,        32'h00001234, 1'b0, 0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(0, 1'b0, 3'b010, 16'h0012, 32'h0,        32'h00000000, 1'b1, 0, 1'b0);
`else
    issue(0, 1'b0, 3'b010, 16'h0012, 32'h0,        32'h1234AAEF, 1'b0, 0, 1'b0);
`endif
    issue(0, 1'b1, 3'b100, 16'h0010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0, 1'b0);
    issue(0, 1'b0, 3'b010, 16'h0010, 32'h0,        32'h1234AAEF, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b110, 16'h0010, 32'h0,        32'h00000000, 1'b1, 0, 1'b0);
    issue(0, 1'b1, 3'b000, 16'hFFFF, 32'h00000080, 32'h00000000, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b000, 16'hFFFF, 32'h0,        32'hFFFFFF80, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 3'b100, 16'hFFFF, 32'h0,        32'h00000080, 1'b0, 0, 1'b0);

    // Three-wait instance: stalled responses, then a store aborted by reset while waiting.
    issue(1, 1'b1, 3'b010, 16'h0020, 32'hCAFEF00D, 32'h00000000, 1'b0, 2, 1'b0);
    issue(1, 1'b0, 3'b010, 16'h0020, 32'h0,        32'hCAFEF00D, 1'b0, 2, 1'b0);
    issue(1, 1'b1, 3'b010, 16'h0020, 32'h12345678, 32'h00000000, 1'b0, 0, 1'b1);
    issue(1, 1'b0, 3'b010, 16'h0020, 32'h0,        32'hCAFEF00D, 1'b0, 0, 1'b0);
    issue(1, 1'b0, 3'b000, 16'h0023, 32'h0,        32'hFFFFFFCA, 1'b0, 1, 1'b0);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d and %0d responses outstanding, required 0", q0.size(), q1.size());
    end
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
